// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port between four write-back
// requesters (0: I-type rt, 1: R-type rd, 2: swi custom, 3: link $31).
// A round-robin arbiter with lock support grants at most one requester per
// cycle. The granted index drives the destination mux select combinationally,
// and the accepted beat is issued through a one-stage registered write-back
// output.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   req_valid    per-requester pending write, held with its data until accepted
//   req_lock     per-requester "keep the port after this beat"
//   req_addr     4 x 5-bit destination register, [5i+4:5i] is requester i
//   req_data     4 x DATA_W write data, slice i is requester i
//   req_ready    one-hot grant; beat accepted when req_valid[i] & req_ready[i]
//   dst_sel      combinational index of the granted requester
//   wb_we        register-file write enable (registered)
//   wb_addr      register-file write address (registered)
//   wb_data      register-file write data (registered)
//   wb_src       requester index of the current wb_* beat (registered)
//   lock_active  arbiter currently locked to one requester (registered)
//
// Lock FSM
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | round-robin search from rr_ptr over all valid requesters
//   ST_LOCKED | only lock_owner may be granted; owner idle cycles are bubbles
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  // Fixed at 4: the destination select is 2 bits wide.
  parameter int NREQ   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_lock,
  input  logic [5*NREQ-1:0]      req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [1:0]             dst_sel,
  output logic                   wb_we,
  output logic [4:0]             wb_addr,
  output logic [DATA_W-1:0]      wb_data,
  output logic [1:0]             wb_src,
  output logic                   lock_active
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          lock_owner_q, lock_owner_d;
  logic                wb_we_q, wb_we_d;
  logic [4:0]          wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [1:0]          wb_src_q, wb_src_d;

  logic                search_found;
  logic [1:0]          search_idx;
  logic [1:0]          cand;
  logic                grant_vld;
  logic [1:0]          grant_idx;
  logic [4:0]          sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_lock;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  // The 2-bit addition wraps modulo 4 on its own.
  always_comb begin
    search_found = 1'b0;
    search_idx   = rr_ptr_q;
    cand         = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!search_found && req_valid[cand]) begin
        search_found = 1'b1;
        search_idx   = cand;
      end
    end
  end

  // Grant selection. With nothing granted in IDLE the select rests on
  // rr_ptr; in a locked bubble it stays parked on the owner.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (search_found) begin
          grant_vld = 1'b1;
          grant_idx = search_idx;
        end
      end
      ST_LOCKED: begin
        grant_idx = lock_owner_q;
        grant_vld = req_valid[lock_owner_q];
      end
      default: begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
      end
    endcase
    if (rst) begin
      grant_vld = 1'b0;
      grant_idx = '0;
    end
  end

  assign req_ready = grant_vld ? (NREQ'(1) << grant_idx) : '0;
  assign dst_sel   = grant_idx;

  // Per-requester payload of the granted beat.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_lock = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == 2'(k)) begin
        sel_addr = req_addr[5*k +: 5];
        sel_data = req_data[DATA_W*k +: DATA_W];
        sel_lock = req_lock[k];
      end
    end
  end

  // Next-state: lock FSM, round-robin pointer and write-back stage.
  // A beat with lock set parks the pointer; the final (unlocked) beat of a
  // burst moves it past the owner exactly like an ordinary grant.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_owner_d = lock_owner_q;
    wb_we_d      = 1'b0;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    wb_src_d     = wb_src_q;

    if (grant_vld) begin
      // Writes to $0 are consumed but never reach the register file.
      wb_we_d   = (sel_addr != 5'd0);
      wb_addr_d = sel_addr;
      wb_data_d = sel_data;
      wb_src_d  = grant_idx;
      if (sel_lock) begin
        state_d      = ST_LOCKED;
        lock_owner_d = grant_idx;
      end else begin
        state_d  = ST_IDLE;
        rr_ptr_d = grant_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      lock_owner_q <= '0;
      wb_we_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      wb_src_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_owner_q <= lock_owner_d;
      wb_we_q      <= wb_we_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      wb_src_q     <= wb_src_d;
    end
  end

  assign wb_we       = wb_we_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign wb_src      = wb_src_q;
  assign lock_active = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Each requester is fed from a queue of beats (addr, data, lock, idle gap
// before the beat). A reference model tracks lock/owner/pointer and the
// expected write-back beat and is compared against the DUT every cycle.
// Directed phases pin the model with literal expectations; a randomized
// phase follows.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [3:0]             req_valid;
  logic [3:0]             req_lock;
  logic [19:0]            req_addr;
  logic [4*DATA_W-1:0]    req_data;
  logic [3:0]             req_ready;
  logic [1:0]             dst_sel;
  logic                   wb_we;
  logic [4:0]             wb_addr;
  logic [DATA_W-1:0]      wb_data;
  logic [1:0]             wb_src;
  logic                   lock_active;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .NREQ(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .dst_sel     (dst_sel),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_src      (wb_src),
    .lock_active (lock_active)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          lock;
    int          gap;
  } beat_t;

  beat_t bq[4][$];
  int n_checks = 0;
  int n_pass   = 0;
  int amap[4]  = '{8, 9, 10, 31};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input int i, input logic [4:0] a, input logic [31:0] d,
                      input bit lk, input int gap);
    beat_t b;
    b.addr = a;
    b.data = d;
    b.lock = lk;
    b.gap  = gap;
    bq[i].push_back(b);
  endtask

  function automatic int pending();
    return bq[0].size() + bq[1].size() + bq[2].size() + bq[3].size();
  endfunction

  task automatic drain();
    int n = 0;
    while ((pending() != 0 || req_valid != 4'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(pending()), 64'd0);
  endtask

  // Requester driver: presents queue heads, pops on accepted handshakes.
  initial begin
    logic [3:0] acc;
    int         gap_cnt[4];
    bit         loaded[4];
    req_valid = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < 4; i++) begin
      gap_cnt[i] = 0;
      loaded[i]  = 1'b0;
    end
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready & {4{~rst}};
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && bq[i].size() > 0) begin
          void'(bq[i].pop_front());
          loaded[i] = 1'b0;
        end
        if (!loaded[i] && bq[i].size() > 0) begin
          gap_cnt[i] = bq[i][0].gap;
          loaded[i]  = 1'b1;
        end
        if (loaded[i] && gap_cnt[i] == 0) begin
          req_valid[i]          = 1'b1;
          req_lock[i]           = bq[i][0].lock;
          req_addr[5*i +: 5]    = bq[i][0].addr;
          req_data[32*i +: 32]  = bq[i][0].data;
        end else begin
          if (loaded[i]) gap_cnt[i]--;
          req_valid[i]          = 1'b0;
          req_lock[i]           = 1'b0;
          req_addr[5*i +: 5]    = '0;
          req_data[32*i +: 32]  = '0;
        end
      end
    end
  end

  // Reference model and per-cycle compare.
  initial begin
    bit          m_locked;
    int          m_owner, m_ptr, m_src, w;
    bit          m_we, g;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [3:0]  pend;
    bit          pend_ok;
    m_locked = 0; m_owner = 0; m_ptr = 0; m_src = 0;
    m_we = 0; m_addr = '0; m_data = '0; pend = '0; pend_ok = 0;
    forever begin
      @(negedge clk);
      g = 0;
      w = 0;
      if (!rst) begin
        if (m_locked) begin
          g = req_valid[m_owner];
          w = m_owner;
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (!g && req_valid[(m_ptr + k) % 4]) begin
              g = 1;
              w = (m_ptr + k) % 4;
            end
          end
        end
      end
      check("req_ready", 64'(req_ready), g ? (64'd1 << w) : 64'd0);
      if (rst)           check("dst_sel_rst", 64'(dst_sel), 64'd0);
      else if (g)        check("dst_sel", 64'(dst_sel), 64'(w));
      else if (!m_locked) check("dst_sel_idle", 64'(dst_sel), 64'(m_ptr));
      check("wb_we", 64'(wb_we), 64'(m_we));
      check("wb_addr", 64'(wb_addr), 64'(m_addr));
      check("wb_data", 64'(wb_data), 64'(m_data));
      check("wb_src", 64'(wb_src), 64'(m_src));
      check("lock_active", 64'(lock_active), 64'(m_locked));
      if (pend_ok) begin
        for (int i = 0; i < 4; i++)
          if (pend[i]) check("protocol_hold", 64'(req_valid[i]), 64'd1);
      end
      pend    = req_valid & ~req_ready;
      pend_ok = !rst;

      if (rst) begin
        m_locked = 0; m_owner = 0; m_ptr = 0;
        m_we = 0; m_addr = '0; m_data = '0; m_src = 0;
      end else if (g) begin
        m_addr = req_addr[5*w +: 5];
        m_data = req_data[32*w +: 32];
        m_we   = (m_addr != 5'd0);
        m_src  = w;
        if (req_lock[w]) begin
          m_locked = 1;
          m_owner  = w;
        end else begin
          m_locked = 0;
          m_ptr    = (w + 1) % 4;
        end
      end else begin
        m_we = 0;
      end
    end
  end

  // Directed phases, then randomized traffic.
  initial begin
    rst = 1'b1;

    // Reset with all requesters valid, then plain round robin.
    for (int i = 0; i < 4; i++) begin
      push(i, 5'(amap[i]), 32'h1000 + 32'(i), 1'b0, 0);
      push(i, 5'(amap[i]), 32'h2000 + 32'(i), 1'b0, 0);
    end
    repeat (2) begin
      @(negedge clk);
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_wb_we", 64'(wb_we), 64'd0);
      check("rst_lock", 64'(lock_active), 64'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_grant", 64'(req_ready), 64'd1 << (k % 4));
      check("rr_dst", 64'(dst_sel), 64'(k % 4));
      if (k > 0) begin
        check("rr_wb_addr", 64'(wb_addr), 64'(amap[(k - 1) % 4]));
        check("rr_wb_we", 64'(wb_we), 64'd1);
      end
    end
    @(negedge clk);
    check("rr_wb_addr_last", 64'(wb_addr), 64'd31);
    check("rr_wb_we_last", 64'(wb_we), 64'd1);

    // Move the pointer to 2 with a single beat from requester 1.
    push(1, 5'd5, 32'h55, 1'b0, 0);
    @(negedge clk);
    check("prep_grant", 64'(req_ready), 64'b0010);
    @(negedge clk);

    // Three-beat locked burst from requester 2 with 0 and 1 contending.
    push(2, 5'd20, 32'hA20, 1'b1, 0);
    push(2, 5'd21, 32'hA21, 1'b1, 0);
    push(2, 5'd22, 32'hA22, 1'b0, 0);
    push(0, 5'd1, 32'hB0, 1'b0, 0);
    push(0, 5'd1, 32'hB1, 1'b0, 0);
    push(1, 5'd2, 32'hC0, 1'b0, 0);
    push(1, 5'd2, 32'hC1, 1'b0, 0);
    @(negedge clk);
    check("lock_g1", 64'(req_ready), 64'b0100);
    check("lock_act0", 64'(lock_active), 64'd0);
    @(negedge clk);
    check("lock_g2", 64'(req_ready), 64'b0100);
    check("lock_act1", 64'(lock_active), 64'd1);
    check("lock_wb1", 64'(wb_addr), 64'd20);
    @(negedge clk);
    check("lock_g3", 64'(req_ready), 64'b0100);
    check("lock_act2", 64'(lock_active), 64'd1);
    @(negedge clk);
    check("lock_after", 64'(req_ready), 64'b0001);
    check("lock_released", 64'(lock_active), 64'd0);
    check("lock_wb3", 64'(wb_addr), 64'd22);
    check("lock_src3", 64'(wb_src), 64'd2);
    drain();

    // Owner bubble of two cycles while requester 1 waits.
    push(2, 5'd12, 32'hD12, 1'b1, 0);
    push(2, 5'd13, 32'hD13, 1'b1, 2);
    push(2, 5'd14, 32'hD14, 1'b0, 0);
    push(1, 5'd7, 32'hE7, 1'b0, 0);
    @(negedge clk);
    check("bub_g0", 64'(req_ready), 64'b0100);
    @(negedge clk);
    check("bub_stall1", 64'(req_ready), 64'b0000);
    check("bub_lock1", 64'(lock_active), 64'd1);
    check("bub_we_first", 64'(wb_we), 64'd1);
    @(negedge clk);
    check("bub_stall2", 64'(req_ready), 64'b0000);
    check("bub_we0_a", 64'(wb_we), 64'd0);
    @(negedge clk);
    check("bub_resume", 64'(req_ready), 64'b0100);
    check("bub_we0_b", 64'(wb_we), 64'd0);
    @(negedge clk);
    check("bub_last", 64'(req_ready), 64'b0100);
    check("bub_wb13", 64'(wb_addr), 64'd13);
    @(negedge clk);
    check("bub_next", 64'(req_ready), 64'b0010);
    check("bub_unlock", 64'(lock_active), 64'd0);
    drain();

    // Write to $0 is consumed but suppressed.
    push(1, 5'd0, 32'hDEADBEEF, 1'b0, 0);
    @(negedge clk);
    check("r0_grant", 64'(req_ready), 64'b0010);
    @(negedge clk);
    check("r0_we", 64'(wb_we), 64'd0);
    check("r0_addr", 64'(wb_addr), 64'd0);
    check("r0_data", 64'(wb_data), 64'hDEADBEEF);
    check("r0_src", 64'(wb_src), 64'd1);
    drain();

    // Reset while locked on requester 3.
    push(3, 5'd3, 32'hF3, 1'b1, 0);
    push(3, 5'd4, 32'hF4, 1'b1, 0);
    push(3, 5'd5, 32'hF5, 1'b0, 0);
    push(0, 5'd6, 32'hF6, 1'b0, 0);
    push(1, 5'd7, 32'hF7, 1'b0, 0);
    @(negedge clk);
    check("rl_g0", 64'(req_ready), 64'b1000);
    @(negedge clk);
    check("rl_g1", 64'(req_ready), 64'b1000);
    check("rl_lock", 64'(lock_active), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rl_rst_ready", 64'(req_ready), 64'b0000);
    check("rl_inflight_we", 64'(wb_we), 64'd1);
    check("rl_inflight_addr", 64'(wb_addr), 64'd4);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rl_unlock", 64'(lock_active), 64'd0);
    check("rl_we_dropped", 64'(wb_we), 64'd0);
    check("rl_lowest", 64'(req_ready), 64'b0001);
    check("rl_dst", 64'(dst_sel), 64'd0);
    drain();

    // Randomized traffic with occasional locks, gaps and resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < 4; i++) begin
        if (bq[i].size() < 2 && $urandom_range(0, 2) != 0)
          push(i,
               ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               $urandom,
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between four write-back requesters: I-type (rt), R-type (rd), swi custom instruction, and link ($31). Each cycle, a round-robin arbiter with lock support grants at most one requester. It drives the 2-bit destination select for the 5-bit destination mux combinationally. It then issues the write through a one-stage registered write-back output. It sits between the execute/memory-side producers and the register file.

Parameters:
DATA_W, 32, width of write-back data
NREQ, 4, number of requesters; fixed at 4 to match the 2-bit destination select

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
req_valid  in  4  requester i has a pending write; held with its data until accepted
req_lock  in  4  requester i keeps the port after this beat (multi-beat, e.g. swi)
req_addr  in  20  4x5-bit destination register per requester; bits [5i+4:5i] belong to requester i
req_data  in  4*DATA_W  write data per requester; slice i belongs to requester i
req_ready  out  4  one-hot grant; beat accepted when req_valid[i] & req_ready[i]
dst_sel  out  2  combinational index of the granted requester; drives the destination mux select
wb_we  out  1  register-file write enable (registered)
wb_addr  out  5  register-file write address (registered)
wb_data  out  DATA_W  register-file write data (registered)
wb_src  out  2  index of the requester that produced the current wb_* beat (registered)
lock_active  out  1  arbiter currently locked to one requester (registered)

Behaviour:
- Reset values (rst high at clock edge): wb_we=0, wb_addr=0, wb_data=0, wb_src=0, lock_active=0, rr_ptr=0, lock_owner=0. While rst is high, req_ready=0 combinationally and dst_sel=0.
- Arbitration (combinational from registered state and req_valid):
  - Unlocked: search req_valid starting at rr_ptr and wrapping modulo 4. The first set bit wins; req_ready is one-hot on the winner, and dst_sel is the winner's index.
  - No valid request: req_ready=0 and dst_sel=rr_ptr.
- Round-robin pointer: on an accepted beat from winner w with req_lock[w]=0, rr_ptr becomes (w+1) mod 4. It is unchanged otherwise.
- Lock state machine, two states:
  - IDLE to LOCKED: beat accepted from w with req_lock[w]=1. Set lock_owner=w and lock_active=1; rr_ptr does not advance.
  - LOCKED: req_ready is only for lock_owner, and only when req_valid[lock_owner]=1. Other requesters are stalled even when valid. A cycle where the owner is not valid is a bubble and the lock holds.
  - LOCKED to IDLE: beat accepted from the owner with req_lock=0. Then rr_ptr becomes (owner+1) mod 4 and lock_active=0.
  - LOCKED with a beat where req_lock stays 1: remain LOCKED.
- Write-back stage: one-cycle latency. On the edge after acceptance, wb_addr=req_addr[w], wb_data=req_data[w], wb_src=w. wb_we=1 unless req_addr[w]==0.
  - Writes to $0 are accepted, consumed and suppressed (wb_we=0), but wb_addr, wb_data and wb_src still update.
- Cycle with no acceptance: wb_we=0 on the next cycle; wb_addr, wb_data and wb_src hold their values.
- Throughput: one beat per cycle sustained, with no dead cycle between different winners.
- Simultaneous valids: exactly one grant per cycle, never more.
- Reset mid-lock: returns to IDLE with rr_ptr=0, and any in-flight wb beat is dropped (wb_we=0).
- A requester deasserting req_valid without acceptance is a protocol violation; the bench asserts it never happens.

Test Plan:
- Reset: assert rst 2 cycles with all four req_valid=1. Required: req_ready=0000, wb_we=0, lock_active=0. First cycle after release: grant 0001, dst_sel=0.
- Round robin: all four valid with addrs 8, 9, 10, 31, no locks, 8 cycles. Required: grants 0,1,2,3,0,1,2,3. wb_addr one cycle later is 8,9,10,31,... and wb_we=1 every cycle.
- Lock: req2 (swi) beats 1 and 2 with lock=1 and beat 3 with lock=0; req0/req1 valid throughout. Required: three consecutive grants to 2, lock_active=1 during the burst, then a grant to 3 if valid, else 0.
- Lock bubble: owner req2 drops req_valid for 2 cycles mid-lock while req1 is valid. Required: no grant to req1, wb_we=0 for 2 cycles, and the lock resumes when req2 is valid again.
- $0 write: req1 alone with addr=0, data=0xDEADBEEF. Required: accepted (req_ready=0010), then wb_we=0, wb_addr=0, wb_data=0xDEADBEEF, wb_src=1.
- Reset mid-lock: assert rst while LOCKED on req3. Required: the next cycle has lock_active=0, wb_we=0 and rr_ptr=0, and the grant after release goes to the lowest valid index.
